// File: rtl/tnn_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tnn_sched_pkg
// Brief   : Shared sample geometry and feature-slice helper for the TNN scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package tnn_sched_pkg;

    localparam int FEAT_N   = 7;
    localparam int FEAT_W   = 2;
    localparam int SAMPLE_W = FEAT_N * FEAT_W;

    typedef logic [SAMPLE_W-1:0] sample_t;

    // LSB position of feature f (a=0 ... g=6) inside a packed sample.
    function automatic int feat_lsb(input int f);
        return f * FEAT_W;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tnn_sched_rr_arb.sv
`default_nettype none
// ============================================================================
// Module  : tnn_sched_rr_arb
// Brief   : Combinational round-robin arbiter; search starts at i_ptr.
// Revision: 1.0 - initial release
// ============================================================================
module tnn_sched_rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_en,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_grant_any
);

    int   w_idx;
    logic w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = 0;
        for (int off = 0; off < N; off++) begin
            w_idx = (int'(i_ptr) + off) % N;
            if (i_en && !w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = IDX_W'(w_idx);
                w_found        = 1'b1;
            end
        end
        o_grant_any = w_found;
    end

endmodule
`default_nettype wire

// File: rtl/tnn_core_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tnn_core_scheduler
// Brief   : Round-robin time-sharing of one TNN classifier core among N_REQ
//           streams, with credit-limited issue and a result FIFO.
//           Optional per-requester positive-class counters: TNN_SCHED_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tnn_core_scheduler
    import tnn_sched_pkg::*;
#(
    parameter  int N_REQ     = 4,
    parameter  int CORE_LAT  = 0,
    parameter  int OUT_DEPTH = 4,
    localparam int ID_W      = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*SAMPLE_W-1:0] req_data,
    output logic [SAMPLE_W-1:0]     core_x,
    input  logic                    core_y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ID_W-1:0]         out_id,
    output logic                    out_class
`ifdef TNN_SCHED_STATS_EN
    ,
    output logic [N_REQ*16-1:0]     stat_pos
`endif
);

    localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
    localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int LINE_N = CORE_LAT + 1;

    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  inflight_q, inflight_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LINE_N-1:0] tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]   tag_id_q [LINE_N];
    logic [ID_W-1:0]   tag_id_d [LINE_N];
    logic [ID_W:0]     fifo_q [OUT_DEPTH];
    logic [ID_W:0]     fifo_d [OUT_DEPTH];
    sample_t           core_x_q, core_x_d;

    sample_t           w_sample;
    logic              w_credit_ok;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;
    logic [N_REQ-1:0]  w_grant;
    logic [ID_W-1:0]   w_grant_idx;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits come only from registered counters, so out_ready never reaches req_ready.
    assign w_credit_ok = ({1'b0, inflight_q} + {1'b0, count_q}) < (CNT_W + 1)'(OUT_DEPTH);

    tnn_sched_rr_arb #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .i_req       (req_valid),
        .i_ptr       (rr_ptr_q),
        .i_en        (w_credit_ok & ~rst),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_grant_any (w_issue)
    );

    assign req_ready = w_grant;

    always_comb begin
        w_sample = '0;
        for (int i = 0; i < N_REQ; i++) begin
            for (int f = 0; f < FEAT_N; f++) begin
                if (w_grant[i]) begin
                    w_sample[feat_lsb(f) +: FEAT_W] = req_data[i*SAMPLE_W + feat_lsb(f) +: FEAT_W];
                end
            end
        end
    end

    always_comb begin
        w_push     = tag_vld_q[LINE_N-1];
        w_pop      = (count_q != '0) && out_ready;

        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = w_issue;
        tag_id_d[0]  = w_grant_idx;
        for (int s = 1; s < LINE_N; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_id_d[s]  = tag_id_q[s-1];
        end

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) begin
            fifo_d[wr_ptr_q] = {tag_id_q[LINE_N-1], core_y};
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (w_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        inflight_d = inflight_q + CNT_W'(w_issue) - CNT_W'(w_push);
        count_d    = count_q + CNT_W'(w_push) - CNT_W'(w_pop);

        rr_ptr_d = rr_ptr_q;
        core_x_d = core_x_q;
        if (w_issue) begin
            rr_ptr_d = (w_grant_idx == ID_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
            core_x_d = w_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q   <= '0;
            inflight_q <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tag_vld_q  <= '0;
            tag_id_q   <= '{default: '0};
            fifo_q     <= '{default: '0};
            core_x_q   <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tag_vld_q  <= tag_vld_d;
            tag_id_q   <= tag_id_d;
            fifo_q     <= fifo_d;
            core_x_q   <= core_x_d;
        end
    end

    assign core_x    = core_x_q;
    assign out_valid = (count_q != '0);
    assign out_id    = out_valid ? fifo_q[rd_ptr_q][ID_W:1] : '0;
    assign out_class = out_valid ? fifo_q[rd_ptr_q][0] : 1'b0;

`ifdef TNN_SCHED_STATS_EN
    logic [15:0] stat_q [N_REQ];
    logic [15:0] stat_d [N_REQ];

    always_comb begin
        stat_d = stat_q;
        if (w_pop && out_class && (stat_q[out_id] != 16'hFFFF)) begin
            stat_d[out_id] = stat_q[out_id] + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= '{default: '0};
        end else begin
            stat_q <= stat_d;
        end
    end

    generate
        for (genvar i = 0; i < N_REQ; i++) begin : g_stat_pack
            assign stat_pos[i*16 +: 16] = stat_q[i];
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_tnn_core_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_tnn_core_scheduler
// Brief   : Self-checking bench: transaction-level reference model plus
//           directed scenarios; XOR stub core. Stats checked with TNN_SCHED_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tnn_core_scheduler;

    localparam int N     = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int SW    = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid, req_ready;
    logic [N*SW-1:0] req_data;
    logic [SW-1:0] core_x;
    logic          core_y;
    logic          out_valid, out_ready, out_class;
    logic [1:0]    out_id;

    logic [N-1:0]  s1_req_valid, s1_req_ready;
    logic [N*SW-1:0] s1_req_data;
    logic [SW-1:0] s1_core_x;
    logic          s1_out_valid, s1_out_ready, s1_out_class;
    logic [1:0]    s1_out_id;

`ifdef TNN_SCHED_STATS_EN
    logic [N*16-1:0] stat_pos, s1_stat_pos;
`endif

    logic [SW-1:0] cx_d1 = '0, cx_d2 = '0;
    always @(posedge clk) begin
        cx_d1 <= core_x;
        cx_d2 <= cx_d1;
    end
    assign core_y = ^cx_d2;

    always #5 clk = ~clk;

    tnn_core_scheduler #(.N_REQ(N), .CORE_LAT(LAT), .OUT_DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .core_x(core_x), .core_y(core_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_class(out_class)
`ifdef TNN_SCHED_STATS_EN
        , .stat_pos(stat_pos)
`endif
    );

    tnn_core_scheduler #(.N_REQ(N), .CORE_LAT(0), .OUT_DEPTH(DEPTH)) u_dut_lat0 (
        .clk(clk), .rst(rst), .req_valid(s1_req_valid), .req_ready(s1_req_ready),
        .req_data(s1_req_data), .core_x(s1_core_x), .core_y(^s1_core_x),
        .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_id(s1_out_id),
        .out_class(s1_out_class)
`ifdef TNN_SCHED_STATS_EN
        , .stat_pos(s1_stat_pos)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: every issued-but-unpopped sample, in issue order.
    int      q_id[$];
    int      q_cls[$];
    int      q_due[$];
    int      m_ptr = 0;
    int      cyc_n = 0;
    int      m_stat[N];
    logic [SW-1:0] m_cx = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(output int hs_idx, output int pop_id);
        int            g;
        logic [N-1:0]  er;
        logic          ev;
        logic [SW-1:0] smp;
`ifdef TNN_SCHED_STATS_EN
        logic [N*16-1:0] est;
`endif
        @(negedge clk);
        g = -1;
        if (!rst && q_id.size() < DEPTH) begin
            for (int o = 0; o < N; o++) begin
                if (g < 0 && req_valid[(m_ptr + o) % N]) g = (m_ptr + o) % N;
            end
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        ev = (q_id.size() > 0) && (q_due[0] <= cyc_n);
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("out_valid", 64'(out_valid), 64'(ev));
        if (ev) begin
            chk("out_id", 64'(out_id), 64'(q_id[0]));
            chk("out_class", 64'(out_class), 64'(q_cls[0]));
        end
        chk("core_x", 64'(core_x), 64'(m_cx));
`ifdef TNN_SCHED_STATS_EN
        for (int i = 0; i < N; i++) est[i*16 +: 16] = 16'(m_stat[i]);
        chk("stat_pos", 64'(stat_pos), 64'(est));
`endif
        hs_idx = -1;
        for (int i = 0; i < N; i++) begin
            if (hs_idx < 0 && req_valid[i] && req_ready[i]) hs_idx = i;
        end
        pop_id = (out_valid && out_ready) ? int'(out_id) : -1;
        smp = (g >= 0) ? req_data[g*SW +: SW] : '0;
        @(posedge clk);
        if (rst) begin
            q_id.delete(); q_cls.delete(); q_due.delete();
            m_ptr = 0; m_cx = '0;
            for (int i = 0; i < N; i++) m_stat[i] = 0;
        end else begin
            if (ev && out_ready) begin
                if (q_cls[0] != 0) m_stat[q_id[0]]++;
                void'(q_id.pop_front()); void'(q_cls.pop_front()); void'(q_due.pop_front());
            end
            if (g >= 0) begin
                q_id.push_back(g);
                q_cls.push_back(int'(^smp));
                q_due.push_back(cyc_n + 2 + LAT);
                m_cx  = smp;
                m_ptr = (g + 1) % N;
            end
        end
        cyc_n++;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, pid, nhs, npop;
        int gq[$];
        int pq[$];
        for (int i = 0; i < N; i++) m_stat[i] = 0;
        rst = 1'b1; req_valid = '1; req_data = '0; out_ready = 1'b0;
        s1_req_valid = '1; s1_req_data = '0; s1_out_ready = 1'b0;

        // Reset values while valid is asserted.
        cyc(hs, pid);
        chk("rst_s1_ready", 64'(s1_req_ready), 64'd0);
        chk("rst_s1_core_x", 64'(s1_core_x), 64'd0);
        chk("rst_s1_out_valid", 64'(s1_out_valid), 64'd0);
        cyc(hs, pid);
        rst = 1'b0; req_valid = '0; s1_req_valid = '0;

        // Single request on a combinational core.
        s1_req_data = '0;
        s1_req_data[2*SW +: SW] = 14'h0001;
        s1_req_valid = 4'b0100; s1_out_ready = 1'b1;
        #1;
        chk("s1_ready", 64'(s1_req_ready), 64'b0100);
        cyc(hs, pid);
        s1_req_valid = '0;
        chk("s1_core_x", 64'(s1_core_x), 64'h0001);
        chk("s1_early_valid", 64'(s1_out_valid), 64'd0);
        cyc(hs, pid);
        chk("s1_out_valid", 64'(s1_out_valid), 64'd1);
        chk("s1_out_id", 64'(s1_out_id), 64'd2);
        chk("s1_out_class", 64'(s1_out_class), 64'd1);
        cyc(hs, pid);
        chk("s1_drained", 64'(s1_out_valid), 64'd0);

        // All requesters contend.
        req_valid = '1; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req_data = (N*SW)'({$urandom(), $urandom()});
            cyc(hs, pid);
            if (hs >= 0) gq.push_back(hs);
            if (pid >= 0) pq.push_back(pid);
        end
        req_valid = '0;
        repeat (10) begin
            cyc(hs, pid);
            if (pid >= 0) pq.push_back(pid);
        end
        chk("sc2_n_grants", 64'(gq.size() >= 8), 64'd1);
        chk("sc2_n_pops", 64'(pq.size() >= 8), 64'd1);
        for (int i = 0; i < 8; i++) begin
            chk("sc2_grant_order", 64'(i < gq.size() ? gq[i] : -1), 64'(i % N));
            chk("sc2_pop_order", 64'(i < pq.size() ? pq[i] : -1), 64'(i % N));
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 250; i++) begin
            req_valid = N'($urandom());
            req_data  = (N*SW)'({$urandom(), $urandom()});
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 63) == 0);
            cyc(hs, pid);
        end
        rst = 1'b0;

        // Backpressure: exactly DEPTH issues, then one per pop.
        req_valid = '0; out_ready = 1'b1;
        repeat (10) cyc(hs, pid);
        req_valid = '1; out_ready = 1'b0; nhs = 0;
        repeat (10) begin
            cyc(hs, pid);
            if (hs >= 0) nhs++;
        end
        chk("sc3_handshakes", 64'(nhs), 64'(DEPTH));
        #1;
        chk("sc3_blocked", 64'(req_ready), 64'd0);
        out_ready = 1'b1;
        cyc(hs, pid);
        chk("sc3_pop", 64'(pid >= 0), 64'd1);
        out_ready = 1'b0;
        cyc(hs, pid);
        chk("sc3_reissue", 64'(hs >= 0), 64'd1);
        nhs = 0;
        repeat (5) begin
            cyc(hs, pid);
            if (hs >= 0) nhs++;
        end
        chk("sc3_no_extra", 64'(nhs), 64'd0);

        // Reset with two tags in flight and one result buffered.
        req_valid = '0; out_ready = 1'b1;
        repeat (10) cyc(hs, pid);
        out_ready = 1'b0; req_valid = 4'b0001;
        repeat (3) cyc(hs, pid);
        req_valid = '0;
        cyc(hs, pid);
        chk("sc4_buffered", 64'(out_valid), 64'd1);
        rst = 1'b1;
        cyc(hs, pid);
        rst = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            chk("sc4_quiet", 64'(out_valid), 64'd0);
            cyc(hs, pid);
        end
        req_valid = '1;
        cyc(hs, pid);
        chk("sc4_first_grant", 64'(hs), 64'd0);

        // Fairness across a dropped request.
        out_ready = 1'b1; req_valid = 4'b1010;
        cyc(hs, pid);
        chk("sc5_grant_a", 64'(hs), 64'd1);
        req_valid = 4'b1001;
        cyc(hs, pid);
        chk("sc5_grant_b", 64'(hs), 64'd3);
        cyc(hs, pid);
        chk("sc5_grant_c", 64'(hs), 64'd0);

        // Twenty positive-class results from requester 0.
        req_valid = '0;
        repeat (10) cyc(hs, pid);
        rst = 1'b1;
        cyc(hs, pid);
        rst = 1'b0;
        req_data = (N*SW)'({$urandom(), $urandom()});
        req_data[0 +: SW] = 14'h0001;
        req_valid = 4'b0001; nhs = 0; npop = 0;
        for (int i = 0; i < 200 && npop < 20; i++) begin
            cyc(hs, pid);
            if (hs >= 0) nhs++;
            if (pid >= 0) npop++;
            if (nhs >= 20) req_valid = '0;
        end
        chk("sc6_pops", 64'(npop), 64'd20);
`ifdef TNN_SCHED_STATS_EN
        chk("sc6_stat_pos", 64'(stat_pos), 64'd20);
`endif
        repeat (4) cyc(hs, pid);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
